// File: rtl/branch_target_encoder.sv
// Reverse branch-target lookup: 64-entry PC target table searched sequentially for the lowest matching index.
// Optional macro BRANCH_TARGET_PRELOAD_EN loads the fixed program table at reset.
module branch_target_encoder #(
  parameter int PC_width = 10,
  parameter int ADDR_W   = 6
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [PC_width-1:0] WrData,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [PC_width-1:0] ReqTarget,
  output logic                RspValid,
  input  logic                RspReady,
  output logic                RspHit,
  output logic [ADDR_W-1:0]   RspAddr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state, state_next;

  logic [PC_width-1:0] entry [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [PC_width-1:0] target;
  logic [ADDR_W-1:0]   idx;
  logic                wr_ok;
  logic                match;

  // Entry 0 is the reserved "PC+1" code and can never hold a target.
  assign wr_ok = WrEn && (WrAddr != '0);
  assign match = valid[idx] && (entry[idx] == target);

`ifdef BRANCH_TARGET_PRELOAD_EN
  localparam logic [DEPTH-1:0] PRELOAD_MASK = {{(DEPTH-14){1'b0}}, 13'h1FFF, 1'b0};

  function automatic logic [PC_width-1:0] preload_value(input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_W'(1):  return PC_width'(28);
      ADDR_W'(2):  return PC_width'(51);
      ADDR_W'(3):  return PC_width'(75);
      ADDR_W'(4):  return PC_width'(28);
      ADDR_W'(5):  return PC_width'(8);
      ADDR_W'(6):  return PC_width'(98);
      ADDR_W'(7):  return PC_width'(53);
      ADDR_W'(8):  return PC_width'(81);
      ADDR_W'(9):  return PC_width'(105);
      ADDR_W'(10): return PC_width'(117);
      ADDR_W'(11): return PC_width'(121);
      ADDR_W'(12): return PC_width'(137);
      ADDR_W'(13): return PC_width'(145);
      default:     return '0;
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid <= PRELOAD_MASK;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry[ADDR_W'(i)] <= preload_value(ADDR_W'(i));
      end
    end else if (wr_ok) begin
      valid[WrAddr] <= 1'b1;
      entry[WrAddr] <= WrData;
    end
  end
`else
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid <= '0;
    end else if (wr_ok) begin
      valid[WrAddr] <= 1'b1;
    end
  end

  // Data needs no reset: validity alone gates every compare.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      entry[WrAddr] <= WrData;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ReqValid) state_next = SCAN;
      SCAN:    if (match || (idx == LAST_IDX)) state_next = RESP;
      RESP:    if (RspReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ReqReady = (state == IDLE);
    RspValid = (state == RESP);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      target  <= '0;
      idx     <= '0;
      RspHit  <= 1'b0;
      RspAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            target <= ReqTarget;
            idx    <= ADDR_W'(1);
          end
        end
        SCAN: begin
          if (match) begin
            RspHit  <= 1'b1;
            RspAddr <= idx;
          end else if (idx == LAST_IDX) begin
            RspHit  <= 1'b0;
            RspAddr <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_target_encoder.sv
// Self-checking bench for branch_target_encoder: directed and random searches against a table-level reference model.
module tb_branch_target_encoder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       WrEn;
  logic [5:0] WrAddr;
  logic [9:0] WrData;
  logic       ReqValid;
  logic       ReqReady;
  logic [9:0] ReqTarget;
  logic       RspValid;
  logic       RspReady;
  logic       RspHit;
  logic [5:0] RspAddr;

  branch_target_encoder #(.PC_width(10), .ADDR_W(6)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqTarget(ReqTarget),
    .RspValid(RspValid), .RspReady(RspReady), .RspHit(RspHit), .RspAddr(RspAddr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  int model_data  [64];
  bit model_valid [64];

  typedef struct {int edge_no; int addr; int data;} wr_t;
  wr_t sched[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      model_valid[i] = 1'b0;
      model_data[i]  = 0;
    end
`ifdef BRANCH_TARGET_PRELOAD_EN
    begin
      int pre [14] = '{0, 28, 51, 75, 28, 8, 98, 53, 81, 105, 117, 121, 137, 145};
      for (int i = 1; i < 14; i++) begin
        model_valid[i] = 1'b1;
        model_data[i]  = pre[i];
      end
    end
`endif
  endfunction

  function automatic void model_write(input int a, input int d);
    if (a != 0) begin
      model_valid[a] = 1'b1;
      model_data[a]  = d;
    end
  endfunction

  // The compare at scan step i sees the table as it was before edge i:
  // a write landing on edge k is visible to index i only when k < i.
  function automatic void ref_search(input int t, output bit hit, output int addr, output int lat);
    hit = 1'b0; addr = 0; lat = 63;
    for (int i = 1; i < 64; i++) begin
      bit v = model_valid[i];
      int d = model_data[i];
      foreach (sched[j]) begin
        if (sched[j].addr == i && sched[j].edge_no < i) begin
          v = 1'b1;
          d = sched[j].data;
        end
      end
      if (v && d == t) begin
        hit = 1'b1; addr = i; lat = i;
        break;
      end
    end
  endfunction

  task automatic write_entry(input int a, input int d);
    WrEn = 1'b1; WrAddr = a[5:0]; WrData = d[9:0];
    step();
    WrEn = 1'b0;
    model_write(a, d);
  endtask

  task automatic run_search(input string name, input int t, input int hold);
    bit eh;
    int ea, el, lat;
    ref_search(t, eh, ea, el);
    check({name, "_req_ready"}, 32'(ReqReady), 32'd1);
    ReqTarget = t[9:0];
    ReqValid  = 1'b1;
    step();
    ReqValid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      WrEn = 1'b0;
      foreach (sched[j]) begin
        if (sched[j].edge_no == k) begin
          WrEn = 1'b1; WrAddr = sched[j].addr[5:0]; WrData = sched[j].data[9:0];
        end
      end
      step();
      if (WrEn) model_write(int'(WrAddr), int'(WrData));
      WrEn = 1'b0;
      if (RspValid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(el));
    check({name, "_hit"}, 32'(RspHit), 32'(eh));
    check({name, "_addr"}, 32'(RspAddr), 32'(ea));
    if (hold > 0 && lat >= 0) begin
      RspReady  = 1'b0;
      ReqValid  = 1'b1;
      ReqTarget = 10'd1;
      for (int i = 0; i < hold; i++) begin
        step();
        check({name, "_hold_valid"}, 32'(RspValid), 32'd1);
        check({name, "_hold_hit"}, 32'(RspHit), 32'(eh));
        check({name, "_hold_addr"}, 32'(RspAddr), 32'(ea));
        check({name, "_hold_req_ready"}, 32'(ReqReady), 32'd0);
      end
      ReqValid = 1'b0;
      RspReady = 1'b1;
    end
    step();
    check({name, "_rsp_done"}, 32'(RspValid), 32'd0);
    check({name, "_back_idle"}, 32'(ReqReady), 32'd1);
    sched.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    ReqValid = 1'b0; ReqTarget = '0; RspReady = 1'b1;
    model_reset();
    #2;
    check("rst_req_ready", 32'(ReqReady), 32'd1);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_rsp_hit", 32'(RspHit), 32'd0);
    check("rst_rsp_addr", 32'(RspAddr), 32'd0);
    #10 Reset_n = 1'b1;
    step();

    run_search("empty_28", 28, 0);

    write_entry(5, 200);
    write_entry(9, 200);
    run_search("dup_200", 200, 0);

    write_entry(0, 77);
    run_search("entry0_77", 77, 0);

    write_entry(40, 300);
    run_search("hold_300", 300, 10);

    sched.push_back('{10, 3, 500});
    sched.push_back('{11, 20, 500});
    run_search("midscan_500", 500, 0);

    write_entry(3, 1);
    sched.push_back('{10, 10, 500});
    run_search("sameidx_500", 500, 0);

    for (int it = 0; it < 24; it++) begin
      int nw, t, a;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        write_entry(int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
      end
      a = int'($urandom_range(0, 63));
      t = ($urandom_range(0, 1) == 1) ? model_data[a] : int'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) begin
        wr_t s;
        s.edge_no = int'($urandom_range(1, 30));
        s.addr    = int'($urandom_range(0, 63));
        s.data    = ($urandom_range(0, 1) == 1) ? t : int'($urandom_range(0, 1023));
        sched.push_back(s);
      end
      run_search("random", t, 0);
    end

    // Asynchronous reset in the middle of a scan that would hit entry 5.
    write_entry(5, 200);
    ReqTarget = 10'd200;
    ReqValid  = 1'b1;
    step();
    ReqValid = 1'b0;
    step();
    step();
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_rsp_valid", 32'(RspValid), 32'd0);
    check("midrst_req_ready", 32'(ReqReady), 32'd1);
    check("midrst_rsp_hit", 32'(RspHit), 32'd0);
    check("midrst_rsp_addr", 32'(RspAddr), 32'd0);
    #2 Reset_n = 1'b1;
    step();
    run_search("after_rst_200", 200, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
